// File: rtl/mc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl_if : sequencer <-> datapath/DRAM handshake and control bundle       |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface mc_ctrl_if;
  logic [31:0] inst;
  logic        halt;
  logic        br_taken;
  logic        mem_ack;

  logic        ir_we;
  logic        pc_we;
  logic [1:0]  npc_op;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [2:0]  sext_op;
  logic        mem_req;
  logic        mem_we;
  logic        illegal;
  logic        bus_err;
  logic [31:0] instret;

  modport master (
    output inst, halt, br_taken, mem_ack,
    input  ir_we, pc_we, npc_op, rf_we, rf_wsel, sext_op,
    input  mem_req, mem_we, illegal, bus_err, instret
  );

  modport slave (
    input  inst, halt, br_taken, mem_ack,
    output ir_we, pc_we, npc_op, rf_we, rf_wsel, sext_op,
    output mem_req, mem_we, illegal, bus_err, instret
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_ctrl  : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer           |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.slave   bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] NPC_SEQ  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_PC4 = 2'd1;
  localparam logic [1:0] WSEL_EXT = 2'd2;
  localparam logic [1:0] WSEL_MEM = 2'd3;

  localparam logic [2:0] SEXT_I = 3'd0;
  localparam logic [2:0] SEXT_S = 3'd1;
  localparam logic [2:0] SEXT_B = 3'd2;
  localparam logic [2:0] SEXT_U = 3'd3;
  localparam logic [2:0] SEXT_J = 3'd4;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic [31:0] instret_q;

  logic [6:0]  opcode;
  logic        is_r, is_ialu, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic        is_legal;
  logic        unused_inst_bits;

  logic        ir_we_c, pc_we_c, rf_we_c, mem_req_c, mem_we_c, illegal_c, bus_err_c;
  logic [1:0]  npc_op_c, rf_wsel_c;
  logic [2:0]  sext_op_c;

  assign opcode           = bus.inst[6:0];
  assign unused_inst_bits = ^bus.inst[31:7];

  assign is_r      = (opcode == OP_R);
  assign is_ialu   = (opcode == OP_IALU);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = (opcode == OP_LUI);
  assign is_legal  = is_r | is_ialu | is_load | is_store | is_branch | is_jal | is_jalr | is_lui;

  always_comb begin
    sext_op_c = SEXT_I;
    if (is_store)       sext_op_c = SEXT_S;
    else if (is_branch) sext_op_c = SEXT_B;
    else if (is_lui)    sext_op_c = SEXT_U;
    else if (is_jal)    sext_op_c = SEXT_J;
  end

  always_comb begin
    next_state = state;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    npc_op_c   = NPC_SEQ;
    rf_we_c    = 1'b0;
    rf_wsel_c  = WSEL_ALU;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    illegal_c  = 1'b0;
    bus_err_c  = 1'b0;

    case (state)
      S_FETCH: begin
        if (!bus.halt) begin
          ir_we_c    = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!is_legal) begin
          illegal_c  = 1'b1;
          pc_we_c    = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_branch) begin
          pc_we_c    = 1'b1;
          npc_op_c   = bus.br_taken ? NPC_BR : NPC_SEQ;
          next_state = S_FETCH;
        end else if (is_load || is_store) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end

      // Ack takes priority over a timeout landing in the same cycle.
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        if (bus.mem_ack) begin
          if (is_store) begin
            pc_we_c    = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          bus_err_c  = 1'b1;
          pc_we_c    = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        if (is_jal || is_jalr) rf_wsel_c = WSEL_PC4;
        else if (is_lui)       rf_wsel_c = WSEL_EXT;
        else if (is_load)      rf_wsel_c = WSEL_MEM;
        if (is_jal)            npc_op_c  = NPC_JAL;
        else if (is_jalr)      npc_op_c  = NPC_JALR;
        next_state = S_FETCH;
      end

      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      wait_cnt  <= 8'd0;
      instret_q <= 32'd0;
    end else begin
      state <= next_state;
      if (state == S_MEM && next_state == S_MEM) wait_cnt <= wait_cnt + 8'd1;
      else                                       wait_cnt <= 8'd0;
      if (pc_we_c) instret_q <= instret_q + 32'd1;
    end
  end

  // Reset masks every output in the same cycle so no DRAM request leaks out.
  assign bus.ir_we   = ir_we_c   & ~rst;
  assign bus.pc_we   = pc_we_c   & ~rst;
  assign bus.rf_we   = rf_we_c   & ~rst;
  assign bus.mem_req = mem_req_c & ~rst;
  assign bus.mem_we  = mem_we_c  & ~rst;
  assign bus.illegal = illegal_c & ~rst;
  assign bus.bus_err = bus_err_c & ~rst;
  assign bus.npc_op  = rst ? 2'd0  : npc_op_c;
  assign bus.rf_wsel = rst ? 2'd0  : rf_wsel_c;
  assign bus.sext_op = rst ? 3'd0  : sext_op_c;
  assign bus.instret = rst ? 32'd0 : instret_q;

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the single-datapath CPU. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states. From the instruction register it drives the decode/writeback stage controls (`rf_we`, `rf_wsel`, `sext_op`) plus the PC, IR and DRAM enables. It also owns the DRAM request/acknowledge handshake, a memory-timeout counter and a retired-instruction counter.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles in MEM waiting for `mem_ack` before abort (range 1–255).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `inst` input 32: current instruction-register contents (valid from DECODE onward).
- `halt` input 1: hold in FETCH while high (no IR load).
- `br_taken` input 1: ALU branch-condition flag, valid in EXEC.
- `mem_ack` input 1: DRAM completion for the current request.
- `ir_we` output 1: load instruction register.
- `pc_we` output 1: update PC.
- `npc_op` output 2: 0 = PC+4, 1 = PC+B-imm, 2 = PC+J-imm, 3 = JALR target.
- `rf_we` output 1: register-file write enable.
- `rf_wsel` output 2: 0 = ALU, 1 = PC+4, 2 = EXT, 3 = DRAM read data.
- `sext_op` output 3: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- `mem_req` output 1: DRAM request, held until ack or abort.
- `mem_we` output 1: DRAM write (store); meaningful only with `mem_req`.
- `illegal` output 1: one-cycle pulse on unsupported opcode.
- `bus_err` output 1: one-cycle pulse on MEM timeout.
- `instret` output 32: count of completed instructions.

## Operation
- Opcode is `inst[6:0]`. Supported opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011
  - BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111
- Any other opcode is illegal.
- `sext_op` is decoded combinationally from the opcode in every state:
  - I for I-ALU, LOAD and JALR; S for STORE; B for BRANCH; U for LUI; J for JAL.
  - 0 for R-type and illegal opcodes.
- FETCH: `ir_we`=1 when `halt`=0, then go to DECODE. With `halt`=1 the block stays in FETCH with all enables 0.
- DECODE: all enables 0.
  - Illegal opcode: `illegal`=1, `pc_we`=1, `npc_op`=0, go to FETCH. No register or memory write occurs.
  - Otherwise go to EXEC.
- EXEC:
  - BRANCH: `pc_we`=1; `npc_op` = `br_taken` ? 1 : 0; go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other supported opcodes: go to WB.
- MEM: `mem_req`=1, and `mem_we`=1 for STORE. The wait counter starts at 0 on entry and increments every cycle without ack.
  - `mem_ack`=1: LOAD goes to WB; STORE sets `pc_we`=1, `npc_op`=0 and goes to FETCH.
  - Counter reaches MEM_TIMEOUT−1 without ack: `bus_err`=1, `pc_we`=1, `npc_op`=0, go to FETCH. No register write occurs.
  - If ack and timeout fall in the same cycle, ack wins.
- WB: `rf_we`=1, `pc_we`=1.
  - `rf_wsel`: R/I-ALU → 0; JAL/JALR → 1; LUI → 2; LOAD → 3.
  - `npc_op`: JAL → 2, JALR → 3, otherwise 0.
  - Then go to FETCH.
- `instret` increments by 1 on every cycle with `pc_we`=1, including illegal and aborted instructions. It wraps modulo 2^32.
- `rf_wsel` and `npc_op` read 0 whenever their enable is 0.

## Timing
- All outputs are combinational from the state register, `inst`, `br_taken`, `mem_ack` and the wait counter. State and counters update on the rising edge of `clk`.
- Reset: state = FETCH, wait counter = 0, `instret` = 0. While `rst`=1 every output is 0.
- The first cycle after `rst` falls is FETCH with `ir_we`=1 (if `halt`=0).
- Asserting reset mid-instruction (including in MEM with `mem_req` high) drops `mem_req` in the same cycle. No partial write completes.
- Cycles per instruction, FETCH to FETCH, with W = MEM wait cycles (0 = ack in the first MEM cycle):
  - Illegal: 2. BRANCH: 3. R, I-ALU, LUI, JAL, JALR: 4.
  - STORE: 4 + W. LOAD: 5 + W. Abort: 3 + MEM_TIMEOUT.
- `mem_req` and `mem_we` stay stable for the whole MEM residency. The DRAM must not see a request outside MEM.
- `halt` is sampled only in FETCH. Raising it in other states has no effect until the next FETCH.

## Test plan
- Reset release, `halt`=0, `inst`=0x003100B3 (add x1,x2,x3) → `ir_we` in cycle 1; `rf_we`=1, `rf_wsel`=0, `pc_we`=1 in cycle 4; `instret`=1 after cycle 4.
- `inst`=0x0000A083 (lw), `mem_ack` raised on the third MEM cycle → 7 cycles total; `mem_req` high for 3 cycles with `mem_we`=0; WB shows `rf_wsel`=3 and `sext_op`=0.
- `inst`=0x00208463 (beq), run once with `br_taken`=1 and once with 0 → EXEC cycle shows `pc_we`=1 with `npc_op`=1, then 0. `rf_we` stays 0 throughout; 3 cycles each.
- `inst`=0x0020A023 (sw), `mem_ack` never asserted, MEM_TIMEOUT=16 → `mem_req`/`mem_we` high for 16 cycles; `bus_err` pulses on the 16th with `pc_we`=1; `rf_we` is never 1; `instret` increments.
- `inst`=0x00000017 (auipc, unsupported) → `illegal` pulse in DECODE with `pc_we`=1; back in FETCH on cycle 3; no `rf_we` or `mem_req`.
- `halt`=1 for 5 cycles after reset, then 0 → `ir_we` stays 0 for 5 cycles and first asserts in the 6th. Additionally, `rst` pulsed during a MEM wait → outputs 0 that cycle, then restart in FETCH with `instret`=0.
